// File: rtl/victim_way_tracker.sv
// Per-set valid mask and round-robin pointer for the 8-set, 8-way phased cache,
// with victim-way selection and a sequenced whole-cache flush.
// Optional: define VICTIM_REPL_COUNT_EN to add the saturating repl_count output.
module victim_way_tracker #(
    parameter logic [2:0] PTR_INIT = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [2:0]  fill_set,
    input  logic [2:0]  fill_way,
    input  logic        inval_valid,
    input  logic [2:0]  inval_set,
    input  logic [2:0]  inval_way,
    input  logic        flush_req,
    output logic        flush_busy,
    output logic        flush_done,
    output logic [7:0]  set_full,
    output logic [2:0]  victim0,
    output logic [2:0]  victim1,
    output logic [2:0]  victim2,
    output logic [2:0]  victim3,
    output logic [2:0]  victim4,
    output logic [2:0]  victim5,
    output logic [2:0]  victim6,
    output logic [2:0]  victim7
`ifdef VICTIM_REPL_COUNT_EN
    ,
    output logic [15:0] repl_count
`endif
);

    localparam int unsigned NSETS  = 8;
    localparam int unsigned NWAYS  = 8;
    localparam int unsigned WAY_W  = 3;
    localparam int unsigned SET_W  = 3;
    localparam int unsigned RCNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SET_W-1:0]   r_cnt;
    logic [SET_W-1:0]   w_cnt_nxt;

    logic [NWAYS-1:0]   r_valid     [NSETS];
    logic [WAY_W-1:0]   r_ptr       [NSETS];
    logic [NWAYS-1:0]   w_valid_nxt [NSETS];
    logic [WAY_W-1:0]   w_ptr_nxt   [NSETS];

    logic [NSETS-1:0]   w_full;
    logic               w_flushing;
    logic               w_fill_acc;
    logic               w_inval_acc;
    logic               w_repl;
    logic               w_flush_start;

    // Lowest invalid way wins; a full set falls back to its round-robin pointer.
    function automatic logic [WAY_W-1:0] f_victim(input logic [NWAYS-1:0] v,
                                                  input logic [WAY_W-1:0] p);
        logic [WAY_W-1:0] r;
        r = p;
        for (int w = int'(NWAYS) - 1; w >= 0; w--) begin
            if (!v[w]) begin
                r = WAY_W'(w);
            end
        end
        return r;
    endfunction

    always_comb begin
        w_full = '0;
        for (int s = 0; s < int'(NSETS); s++) begin
            w_full[s] = &r_valid[s];
        end
    end

    assign w_flushing    = (r_state == ST_FLUSH);
    assign w_fill_acc    = fill_valid && !w_flushing;
    assign w_inval_acc   = inval_valid && !w_flushing;
    assign w_repl        = w_fill_acc && w_full[fill_set];
    assign w_flush_start = (r_state == ST_IDLE) && flush_req;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state: one set cleared per FLUSH cycle, DONE lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (flush_req) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FLUSH: begin
                w_cnt_nxt = r_cnt + SET_W'(1);
                if (r_cnt == SET_W'(NSETS - 1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Invalidate is applied before fill so a same-way collision leaves the bit set.
    always_comb begin
        for (int s = 0; s < int'(NSETS); s++) begin
            w_valid_nxt[s] = r_valid[s];
            w_ptr_nxt[s]   = r_ptr[s];
        end
        if (w_flushing) begin
            w_valid_nxt[r_cnt] = '0;
            w_ptr_nxt[r_cnt]   = PTR_INIT;
        end else begin
            if (w_inval_acc) begin
                w_valid_nxt[inval_set][inval_way] = 1'b0;
            end
            if (w_fill_acc) begin
                w_valid_nxt[fill_set][fill_way] = 1'b1;
            end
            if (w_repl) begin
                w_ptr_nxt[fill_set] = r_ptr[fill_set] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(NSETS); s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= PTR_INIT;
            end
        end else begin
            for (int s = 0; s < int'(NSETS); s++) begin
                r_valid[s] <= w_valid_nxt[s];
                r_ptr[s]   <= w_ptr_nxt[s];
            end
        end
    end

`ifdef VICTIM_REPL_COUNT_EN
    logic [RCNT_W-1:0] r_repl_count;

    // Flush entry clears the counter even if a replacement fill lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_repl_count <= '0;
        end else if (w_flush_start) begin
            r_repl_count <= '0;
        end else if (w_repl && (r_repl_count != {RCNT_W{1'b1}})) begin
            r_repl_count <= r_repl_count + RCNT_W'(1);
        end
    end

    assign repl_count = r_repl_count;
`else
    logic w_unused;
    assign w_unused = w_flush_start ^ ^RCNT_W'(0);
`endif

    assign fill_ready = !w_flushing;
    assign flush_busy = w_flushing;
    assign flush_done = (r_state == ST_DONE);
    assign set_full   = w_full;

    assign victim0 = f_victim(r_valid[0], r_ptr[0]);
    assign victim1 = f_victim(r_valid[1], r_ptr[1]);
    assign victim2 = f_victim(r_valid[2], r_ptr[2]);
    assign victim3 = f_victim(r_valid[3], r_ptr[3]);
    assign victim4 = f_victim(r_valid[4], r_ptr[4]);
    assign victim5 = f_victim(r_valid[5], r_ptr[5]);
    assign victim6 = f_victim(r_valid[6], r_ptr[6]);
    assign victim7 = f_victim(r_valid[7], r_ptr[7]);

endmodule

// File: doc/victim_way_tracker.md
Name: victim_way_tracker

Overview:
- Per-set replacement-state block for the 8-set, 8-way phased cache.
- Holds a valid mask and a round-robin replacement pointer for each set, and produces one 3-bit victim-way index per set.
- The eight victim_s buses feed the downstream 8-to-1 3-bit selector, which the set index drives.
- Also tracks fill and invalidate traffic, and performs a sequenced whole-cache flush.

Parameters:
PTR_INIT, 3'd0, reset/flush value loaded into every set's replacement pointer.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
fill_valid  input  1  fill request.
fill_ready  output  1  fill accepted when fill_valid && fill_ready at a clock edge.
fill_set  input  3  set being filled.
fill_way  input  3  way being filled.
inval_valid  input  1  invalidate request; single-cycle, always accepted outside flush.
inval_set  input  3  set to invalidate.
inval_way  input  3  way to invalidate.
flush_req  input  1  start whole-cache flush.
flush_busy  output  1  high while the flush sweep runs.
flush_done  output  1  one-cycle pulse when the flush completes.
set_full  output  8  bit s = all 8 ways of set s valid.
victim0..victim7  output  3 each  victim way for sets 0..7, feeds the 8-to-1 3-bit selector.

Behaviour:
- State per set s: valid[s][7:0] and ptr[s][2:0], all registers.
- victim_s (combinational from state registers only; no input-to-output path):
  - If valid[s] != 8'hFF: index of the lowest-numbered invalid way.
  - Otherwise: ptr[s].
- set_full[s] = &valid[s].
- Reset (rst_n low, asynchronous):
  - All valid = 0; all ptr = PTR_INIT; FSM = IDLE; flush count = 0.
  - Outputs: victim_s = 0, set_full = 0, flush_busy = 0, flush_done = 0, fill_ready = 1.
  - Reset mid-flush abandons the sweep with no flush_done pulse.
- Fill accepted (fill_valid && fill_ready):
  - valid[fill_set][fill_way] <= 1.
  - If set_full[fill_set] was 1 before the edge (replacement fill), ptr[fill_set] <= ptr + 1 mod 8; 7 wraps to 0.
  - Otherwise ptr is unchanged.
  - fill_way is not checked against victim; the requester is trusted.
- Invalidate (inval_valid, FSM in IDLE): valid[inval_set][inval_way] <= 0; ptr unchanged.
- Simultaneous fill and invalidate:
  - Same set and same way: fill wins, bit ends at 1.
  - Same set, different ways: both apply; the pointer-advance decision uses the pre-edge set_full.
  - Different sets: independent.
- Effect timing: updated state is visible on victim_s/set_full in the cycle after the accepting edge.
- FSM:
  - IDLE: flush_req -> FLUSH, cnt <= 0.
  - FLUSH:
    - Each cycle: valid[cnt] <= 0, ptr[cnt] <= PTR_INIT, cnt <= cnt + 1.
    - When cnt == 7 -> DONE.
    - Exactly 8 cycles.
    - flush_busy = 1; fill_ready = 0; inval_valid and flush_req are ignored.
  - DONE: flush_done = 1 for one cycle -> IDLE; fill_ready = 1; inval is accepted; flush_req is ignored.
- flush_busy and flush_done are registered (decoded from state register). fill_ready = (state != FLUSH).
- Latency: flush_req edge to flush_done high = 9 cycles.

Optional Feature:
- Macro: VICTIM_REPL_COUNT_EN.
- When defined:
  - Adds output repl_count [15:0].
  - Increments on every accepted replacement fill (set_full[fill_set] = 1 before the edge).
  - Saturates at 16'hFFFF.
  - Cleared by reset and on entering FLUSH.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset release -> victim0..7 = 0, set_full = 8'h00, fill_ready = 1, flush_busy = 0; with the macro, repl_count = 0.
- Fill set 2 ways 0..7 in order -> victim2 = 1,2,...,7 after each fill; after the 8th fill set_full = 8'h04 and victim2 = PTR_INIT (0).
- Set 2 full, fill set 2 way 0 eight more times -> ptr and victim2 step 1,2,...,7,0 (wrap); with the macro, repl_count = 8.
- Set 5 full, ptr = 3; same-cycle fill way 4 and inval way 6 -> valid[5] = 8'hBF, victim5 = 6, ptr[5] = 4 (pre-edge full).
- Same-cycle fill and inval of set 1 way 3 from valid[1] = 8'h00 -> valid[1] = 8'h08, victim1 = 0.
- Several sets populated, pulse flush_req -> flush_busy high for cycles 1..8, fill_valid held high is not accepted, flush_done pulses on cycle 9, then all victims = 0, set_full = 0.
- Reset asserted on flush cycle 4 -> no flush_done, all state at reset values immediately.
